ps2_rx_fifo: RTL and testbench

//  PS/2 device-to-host receiver feeding the keyboard scan-code decoder.

---
 rtl/ps2_rx_fifo_if.sv | 20 ++
 rtl/ps2_rx_fifo.sv | 123 ++++++++++++
 tb/tb_ps2_rx_fifo.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_rx_fifo_if.sv
// PS/2 receiver bundle: raw connector lines, consumer pop strobe and FIFO status.
interface ps2_rx_fifo_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic       nextdata_n;
    logic [7:0] data;
    logic       ready;
    logic       overflow;
    logic       frame_err;

    modport master (
        output ps2_clk, ps2_data, nextdata_n,
        input  data, ready, overflow, frame_err
    );

    modport slave (
        input  ps2_clk, ps2_data, nextdata_n,
        output data, ready, overflow, frame_err
    );
endinterface

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronises the raw lines, deframes 11-bit frames
// and queues good scan codes in a small FIFO popped by falling edges of nextdata_n.
module ps2_rx_fifo #(
    parameter int unsigned FIFO_AW     = 3,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic         clk,
    input  logic         clrn,
    ps2_rx_fifo_if.slave bus
);
    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned TW    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [FIFO_AW:0] FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [TW-1:0]    TO_LIM   = TW'(TIMEOUT_CYC);

    logic [2:0]         r_clk_sync;
    logic [1:0]         r_dat_sync;
    logic [9:0]         r_shift;
    logic [3:0]         r_bit_cnt;
    logic [TW-1:0]      r_idle;
    logic               r_timeout;
    logic               r_done;
    logic               r_ok;
    logic [7:0]         r_byte;
    logic [7:0]         r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wptr;
    logic [FIFO_AW-1:0] r_rptr;
    logic [FIFO_AW:0]   r_count;
    logic               r_nd_prev;
    logic               r_ovf;
    logic               r_frame_err;

    logic w_fall;
    logic w_bit;
    logic w_pop;
    logic w_full;
    logic w_wr;

    assign w_fall = r_clk_sync[2] & ~r_clk_sync[1];
    assign w_bit  = r_dat_sync[1];

    // Deframer: r_shift holds {parity, d7..d0, start} once ten bits are in.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_clk_sync <= 3'b111;
            r_dat_sync <= 2'b11;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_idle     <= '0;
            r_timeout  <= 1'b0;
            r_done     <= 1'b0;
            r_ok       <= 1'b0;
            r_byte     <= '0;
        end else begin
            r_clk_sync <= {r_clk_sync[1:0], bus.ps2_clk};
            r_dat_sync <= {r_dat_sync[0], bus.ps2_data};
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
            if (w_fall) begin
                r_idle <= '0;
                if (r_bit_cnt == 4'd10) begin
                    r_bit_cnt <= '0;
                    r_done    <= 1'b1;
                    r_byte    <= r_shift[8:1];
                    r_ok      <= ~r_shift[0] & w_bit & (^r_shift[9:1]);
                end else begin
                    r_shift   <= {w_bit, r_shift[9:1]};
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end
            end else if (r_bit_cnt == 4'd0) begin
                r_idle <= '0;
            end else if (r_idle == TO_LIM) begin
                r_bit_cnt <= '0;
                r_idle    <= '0;
                r_timeout <= 1'b1;
            end else begin
                r_idle <= r_idle + 1'b1;
            end
        end
    end

    assign w_pop  = r_nd_prev & ~bus.nextdata_n & (r_count != '0);
    assign w_full = (r_count == FULL_CNT);
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the write.
    assign w_wr   = r_done & r_ok & (~w_full | w_pop);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_nd_prev   <= 1'b1;
            r_ovf       <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_nd_prev   <= bus.nextdata_n;
            r_frame_err <= (r_done & ~r_ok) | r_timeout;
            if (r_done & r_ok & ~w_wr) begin
                r_ovf <= 1'b1;
            end
            if (w_wr) begin
                r_mem[r_wptr] <= r_byte;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_wr && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_wr && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign bus.data      = r_mem[r_rptr];
    assign bus.ready     = (r_count != '0);
    assign bus.overflow  = r_ovf;
    assign bus.frame_err = r_frame_err;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: directed scenarios plus random frames and pops, checked every
// cycle against a queue-based model of the receiver.
module tb_ps2_rx_fifo;
    localparam int unsigned AW    = 3;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned TO    = 300;

    logic clk  = 1'b0;
    logic clrn = 1'b0;

    ps2_rx_fifo_if bus ();

    ps2_rx_fifo #(
        .FIFO_AW    (AW),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk (clk),
        .clrn(clrn),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         at;
        bit         ok;
        logic [7:0] b;
    } ev_t;

    int         n_chk = 0;
    int         n_err = 0;
    int         cyc   = 0;
    int         fe_total = 0;
    bit         fe_dc = 1'b0;
    bit         rand_done = 1'b0;
    logic [7:0] mq [$];
    ev_t        evq [$];
    bit         m_ovf = 1'b0;
    bit         m_fe = 1'b0;
    bit         m_prev_nd = 1'b1;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endfunction

    // Reference model: a frame finishing with the stop-bit fall driven just before edge k
    // takes effect at edge k+3 (2 sync flops, then 2 edges); pops act on the next edge.
    always @(posedge clk) begin : model
        bit         pop;
        bit         wr;
        logic [7:0] wb;
        ev_t        e;
        cyc++;
        if (!clrn) begin
            mq.delete();
            evq.delete();
            m_ovf     = 1'b0;
            m_fe      = 1'b0;
            m_prev_nd = 1'b1;
        end else begin
            pop       = m_prev_nd && !bus.nextdata_n && (mq.size() > 0);
            m_prev_nd = bus.nextdata_n;
            m_fe      = 1'b0;
            wr        = 1'b0;
            wb        = 8'h00;
            while (evq.size() > 0 && evq[0].at == cyc) begin
                e = evq.pop_front();
                if (e.ok) begin
                    if (mq.size() < DEPTH || pop) begin
                        wr = 1'b1;
                        wb = e.b;
                    end else begin
                        m_ovf = 1'b1;
                    end
                end else begin
                    m_fe = 1'b1;
                end
            end
            if (pop) void'(mq.pop_front());
            if (wr) mq.push_back(wb);
        end
    end

    always @(negedge clk) begin : compare
        if (clrn) begin
            if (bus.frame_err === 1'b1) fe_total++;
            chk("ready", {31'd0, bus.ready}, {31'd0, mq.size() != 0});
            if (mq.size() != 0) chk("data", {24'd0, bus.data}, {24'd0, mq[0]});
            chk("overflow", {31'd0, bus.overflow}, {31'd0, m_ovf});
            if (!fe_dc) chk("frame_err", {31'd0, bus.frame_err}, {31'd0, m_fe});
        end
    end

    // kind: 0 good, 1 bad start, 2 bad parity, 3 bad stop.
    task automatic send_frame(input logic [7:0] b, input int kind, input int nbits);
        logic [10:0] bits;
        bit          ok;
        ev_t         e;
        bits[0]    = (kind == 1);
        bits[8:1]  = b;
        bits[9]    = ~(^b) ^ (kind == 2);
        bits[10]   = ~(kind == 3);
        ok = (bits[0] == 1'b0) && (bits[10] == 1'b1) && ((^bits[9:1]) == 1'b1);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            bus.ps2_data = bits[i];
            repeat (5) @(negedge clk);
            bus.ps2_clk = 1'b0;
            if (i == 10) begin
                e.at = cyc + 4;
                e.ok = ok;
                e.b  = b;
                evq.push_back(e);
            end
            repeat (10) @(negedge clk);
            bus.ps2_clk = 1'b1;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic pop1();
        @(negedge clk);
        bus.nextdata_n = 1'b0;
        repeat (2) @(negedge clk);
        bus.nextdata_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, {31'd0, bus.ready}, 32'd0);
        chk({tag, "_data"}, {24'd0, bus.data}, 32'd0);
        chk({tag, "_overflow"}, {31'd0, bus.overflow}, 32'd0);
        chk({tag, "_frame_err"}, {31'd0, bus.frame_err}, 32'd0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int fe0;
        bus.ps2_clk    = 1'b1;
        bus.ps2_data   = 1'b1;
        bus.nextdata_n = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        clrn = 1'b1;
        repeat (3) @(negedge clk);

        // Single good frame 0x1C.
        send_frame(8'h1C, 0, 11);
        chk("f1c_data", {24'd0, bus.data}, 32'h1C);
        chk("f1c_ready", {31'd0, bus.ready}, 32'd1);
        pop1();
        chk("f1c_empty", {31'd0, bus.ready}, 32'd0);

        // Same frame with wrong parity.
        fe0 = fe_total;
        send_frame(8'h1C, 2, 11);
        chk("parity_fe_cnt", fe_total - fe0, 32'd1);
        chk("parity_ready", {31'd0, bus.ready}, 32'd0);

        // Nine frames with no pops overflow the 8-entry FIFO.
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 11);
        chk("ovf_flag", {31'd0, bus.overflow}, 32'd1);
        for (int i = 1; i <= 8; i++) begin
            chk("ovf_pop_data", {24'd0, bus.data}, i);
            pop1();
        end
        chk("ovf_drained", {31'd0, bus.ready}, 32'd0);

        // Partial frame then idle past the timeout, then a full frame.
        fe_dc = 1'b1;
        fe0   = fe_total;
        send_frame(8'hA5, 0, 5);
        repeat (TO + 60) @(negedge clk);
        fe_dc = 1'b0;
        chk("timeout_fe_cnt", fe_total - fe0, 32'd1);
        send_frame(8'hF0, 0, 11);
        chk("timeout_data", {24'd0, bus.data}, 32'hF0);
        pop1();

        // nextdata_n held low pops only once.
        send_frame(8'h11, 0, 11);
        send_frame(8'h22, 0, 11);
        send_frame(8'h33, 0, 11);
        @(negedge clk);
        bus.nextdata_n = 1'b0;
        repeat (200) @(negedge clk);
        bus.nextdata_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("hold_data", {24'd0, bus.data}, 32'h22);
        pop1();
        chk("hold_data2", {24'd0, bus.data}, 32'h33);
        pop1();
        chk("hold_empty", {31'd0, bus.ready}, 32'd0);

        // Reset mid-frame discards the partial frame and clears sticky overflow.
        send_frame(8'h5A, 0, 6);
        @(negedge clk);
        #1 clrn = 1'b0;
        @(negedge clk);
        chk_reset_outputs("midreset");
        @(negedge clk);
        clrn = 1'b1;
        repeat (3) @(negedge clk);
        send_frame(8'h1C, 0, 11);
        chk("postreset_data", {24'd0, bus.data}, 32'h1C);
        chk("postreset_ready", {31'd0, bus.ready}, 32'd1);
        pop1();

        // Random frames against random pops.
        fork
            begin
                for (int n = 0; n < 40; n++) begin
                    int k;
                    k = int'($urandom_range(0, 9));
                    send_frame(8'($urandom_range(0, 255)), (k <= 3) ? k : 0, 11);
                    repeat ($urandom_range(0, 8)) @(negedge clk);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    repeat ($urandom_range(1, 400)) @(negedge clk);
                    bus.nextdata_n = 1'b0;
                    repeat ($urandom_range(1, 6)) @(negedge clk);
                    bus.nextdata_n = 1'b1;
                end
            end
        join
        repeat (10) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
